tt_sweep_capture: RTL and testbench
===================================

// Module: tt_sweep_capture
// PURPOSE
// - Downstream truth-table collector for the 7-input majority-network classifier blocks.
// - Sweeps every input minterm onto x0..x6 of the function under test (FUT).
// - Samples the FUT's single-bit out and assembles the 2^N_IN-bit truth table.
// - Compares the assembled table against an expected table and reports match and onset size.
// - Result is handed off with a valid/ready handshake.
// PARAMETERS
// - N_IN        default 7  number of FUT inputs; table width is 2^N_IN
// - SAMPLE_DLY  default 0  extra cycles each minterm is held before sampling (covers FUT pipelining)
// PORTS
// - clk        in   1          rising-edge clock
// - rst_n      in   1          asynchronous active-low reset
// - start      in   1          begin sweep; honoured only in IDLE
// - abort      in   1          synchronous; cancels a sweep in DRIVE
// - exp_tt     in   2^N_IN     expected truth table; latched on accepted start
// - x_vec      out  N_IN       minterm driven to FUT; x_vec[0]=x0 ... x_vec[6]=x6
// - dut_out    in   1          FUT output for the current x_vec
// - busy       out  1          high in DRIVE
// - tt         out  2^N_IN     captured table; bit i = f(minterm i); hex MSB = minterm 2^N_IN-1
// - ones_count out  N_IN+1     number of 1s in tt (onset size)
// - match      out  1          tt == latched exp_tt; meaningful while tt_valid
// - tt_valid   out  1          result available
// - tt_ready   in   1          consumer accepts result
// BEHAVIOUR
// - Reset values: x_vec=0, tt=0, ones_count=0, match=0, tt_valid=0, busy=0. FSM resets to IDLE.
// - FSM states: IDLE, DRIVE, DONE. All outputs are registered.
// - IDLE: start=1 at an edge latches exp_tt and sets idx=0, hold=0, tt=0, ones_count=0.
//   - Same edge: go to DRIVE with x_vec=0.
// - DRIVE: x_vec=idx. hold counts 0..SAMPLE_DLY.
//   - hold<SAMPLE_DLY: increment hold.
//   - hold==SAMPLE_DLY: tt[idx]<=dut_out; ones_count+=dut_out; hold<=0.
//   - After that sample, idx==2^N_IN-1 -> DONE; otherwise idx++.
// - Latency: tt_valid rises exactly 2^N_IN*(SAMPLE_DLY+1) cycles after the start edge (128 for defaults).
// - DONE: tt_valid=1; tt, ones_count and match stay stable.
//   - match = (tt == exp_tt), computed on the DONE-entry edge including the final bit.
//   - tt_valid && tt_ready -> IDLE; tt_valid drops the next cycle. tt and ones_count hold until the next start.
// - Ignored inputs:
//   - start outside IDLE is ignored and never queued.
//   - exp_tt changes after latching have no effect.
// - abort:
//   - In DRIVE: go to IDLE and set x_vec=0; tt_valid is not raised and tt holds the partial value.
//   - In IDLE/DONE: ignored.
//   - abort and the final sample on the same edge: abort wins, no tt_valid.
// - ones_count is N_IN+1 bits wide; its maximum value 2^N_IN fits without wrap.
// - idx wraps never: the sweep ends at 2^N_IN-1.
// - rst_n low mid-sweep: immediate return to reset values, no partial result.
// CONFIGURATION
// - TT_MISMATCH_IDX_EN defined: adds outputs
//   - first_mm out N_IN: lowest minterm where tt differs from exp_tt; 0 when none
//   - mm_valid out 1: high when at least one bit differs
//   - Both are updated on the DONE-entry edge and reset to 0.
// - TT_MISMATCH_IDX_EN undefined: these ports and their logic are absent; all other behaviour is identical.
// TESTING
// - FUT = 7-input majority network, exp_tt=128'hfeeaeeeafaeae880fee8a8a0a888a880
//   -> tt=exp_tt, match=1, ones_count=64, tt_valid at cycle 128.
// - FUT out=x6, exp_tt=128'hffffffffffffffff0000000000000000
//   -> match=1, ones_count=64. Constant-0 FUT -> tt=0, ones_count=0.
// - Majority FUT, exp_tt with bit 5 flipped
//   -> match=0; with TT_MISMATCH_IDX_EN: first_mm=5, mm_valid=1.
// - tt_ready held low 10 cycles in DONE, start pulsed meanwhile
//   -> tt_valid and tt stay stable, no new sweep; release -> IDLE.
// - abort asserted while x_vec=40 -> IDLE next cycle, x_vec=0, tt_valid never rises.
//   - rst_n pulsed at x_vec=70 -> all outputs 0 immediately.
// - SAMPLE_DLY=2, FUT registered by 2 stages, majority exp_tt
//   -> match=1, tt_valid exactly 384 cycles after start.

Source files
------------

// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture: truth-table collector for a single-output function under test.
// Sweeps every minterm onto x_vec, samples dut_out after SAMPLE_DLY extra hold
// cycles, assembles the 2^N_IN-bit table, compares it with a latched expected
// table and hands the result off with a valid/ready handshake.
// Optional feature macro: TT_MISMATCH_IDX_EN adds first_mm / mm_valid outputs
// reporting the lowest differing minterm.
module tt_sweep_capture #(
    parameter int N_IN       = 7,
    parameter int SAMPLE_DLY = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [(1<<N_IN)-1:0]     exp_tt,
    output logic [N_IN-1:0]          x_vec,
    input  logic                     dut_out,
    output logic                     busy,
    output logic [(1<<N_IN)-1:0]     tt,
    output logic [N_IN:0]            ones_count,
    output logic                     match,
    output logic                     tt_valid,
    input  logic                     tt_ready
`ifdef TT_MISMATCH_IDX_EN
    ,
    output logic [N_IN-1:0]          first_mm,
    output logic                     mm_valid
`endif
);

    localparam int TTW = 1 << N_IN;
    localparam int HW  = (SAMPLE_DLY > 0) ? $clog2(SAMPLE_DLY + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [N_IN-1:0]   r_xVec;
    logic [HW-1:0]     r_hold;
    logic [TTW-1:0]    r_tt;
    logic [TTW-1:0]    r_expTt;
    logic [N_IN:0]     r_onesCount;
    logic              r_match;
    logic              r_ttValid;
    logic              r_busy;

    logic              w_sample;
    logic              w_last;
    logic [TTW-1:0]    w_ttNext;
    logic [N_IN:0]     w_onesNext;

    // Sample strobe, last-minterm flag and the table/count as they will look after this sample.
    always_comb begin
        w_sample            = (r_hold == HW'(SAMPLE_DLY));
        w_last              = &r_xVec;
        w_ttNext            = r_tt;
        w_ttNext[r_xVec]    = dut_out;
        w_onesNext          = r_onesCount + (N_IN+1)'(dut_out);
    end

    // Next-state logic; abort in DRIVE takes priority over the final sample.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = DRIVE;
                end
            end
            DRIVE: begin
                if (abort) begin
                    w_nextState = IDLE;
                end else if (w_sample && w_last) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (tt_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Registered status flags derived from the upcoming state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy    <= 1'b0;
            r_ttValid <= 1'b0;
        end else begin
            r_busy    <= (w_nextState == DRIVE);
            r_ttValid <= (w_nextState == DONE);
        end
    end

    // Sweep datapath: minterm index, hold counter, table assembly, onset count and match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xVec      <= '0;
            r_hold      <= '0;
            r_tt        <= '0;
            r_expTt     <= '0;
            r_onesCount <= '0;
            r_match     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_expTt     <= exp_tt;
                        r_xVec      <= '0;
                        r_hold      <= '0;
                        r_tt        <= '0;
                        r_onesCount <= '0;
                        r_match     <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        r_xVec <= '0;
                        r_hold <= '0;
                    end else if (!w_sample) begin
                        r_hold <= r_hold + HW'(1);
                    end else begin
                        r_tt        <= w_ttNext;
                        r_onesCount <= w_onesNext;
                        r_hold      <= '0;
                        if (w_last) begin
                            r_match <= (w_ttNext == r_expTt);
                        end else begin
                            r_xVec <= r_xVec + N_IN'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef TT_MISMATCH_IDX_EN
    logic [TTW-1:0]  w_diff;
    logic [N_IN-1:0] w_firstMm;
    logic [N_IN-1:0] r_firstMm;
    logic            r_mmValid;

    // Lowest differing minterm between the final table and the expected one.
    always_comb begin
        w_diff    = w_ttNext ^ r_expTt;
        w_firstMm = '0;
        for (int i = TTW - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_firstMm = N_IN'(i);
            end
        end
    end

    // Mismatch report captured on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_firstMm <= '0;
            r_mmValid <= 1'b0;
        end else if (r_state == DRIVE && !abort && w_sample && w_last) begin
            r_firstMm <= w_firstMm;
            r_mmValid <= |w_diff;
        end
    end

    assign first_mm = r_firstMm;
    assign mm_valid = r_mmValid;
`endif

    assign x_vec      = r_xVec;
    assign busy       = r_busy;
    assign tt         = r_tt;
    assign ones_count = r_onesCount;
    assign match      = r_match;
    assign tt_valid   = r_ttValid;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb_tt_sweep_capture: randomized self-checking bench for tt_sweep_capture.
// Instance A uses default parameters with a combinational table-driven FUT;
// instance B uses SAMPLE_DLY=2 with a FUT registered by two stages.
// Honours TT_MISMATCH_IDX_EN when defined.
module tb_tt_sweep_capture;

    localparam logic [127:0] MAJ = 128'hfeeaeeeafaeae880fee8a8a0a888a880;

    logic         clk;
    logic         rst_n;

    // Instance A signals
    logic         start;
    logic         abort;
    logic [127:0] expTt;
    logic [6:0]   xVec;
    logic         dutOut;
    logic         busy;
    logic [127:0] tt;
    logic [7:0]   onesCount;
    logic         match;
    logic         ttValid;
    logic         ttReady;
    logic [127:0] futTable;

    // Instance B signals
    logic         startB;
    logic         abortB;
    logic [127:0] expTtB;
    logic [6:0]   xVecB;
    logic         dutOutB;
    logic         busyB;
    logic [127:0] ttB;
    logic [7:0]   onesCountB;
    logic         matchB;
    logic         ttValidB;
    logic         ttReadyB;
    logic [127:0] tableB;
    logic         pipe1B;
    logic         pipe2B;

`ifdef TT_MISMATCH_IDX_EN
    logic [6:0]   firstMm;
    logic         mmValid;
    logic [6:0]   firstMmB;
    logic         mmValidB;
`endif

    int assertCount = 0;
    int failCount   = 0;

    tt_sweep_capture #(.N_IN(7), .SAMPLE_DLY(0)) dutA (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(expTt),
        .x_vec(xVec), .dut_out(dutOut), .busy(busy), .tt(tt), .ones_count(onesCount),
        .match(match), .tt_valid(ttValid), .tt_ready(ttReady)
`ifdef TT_MISMATCH_IDX_EN
        , .first_mm(firstMm), .mm_valid(mmValid)
`endif
    );

    tt_sweep_capture #(.N_IN(7), .SAMPLE_DLY(2)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .abort(abortB), .exp_tt(expTtB),
        .x_vec(xVecB), .dut_out(dutOutB), .busy(busyB), .tt(ttB), .ones_count(onesCountB),
        .match(matchB), .tt_valid(ttValidB), .tt_ready(ttReadyB)
`ifdef TT_MISMATCH_IDX_EN
        , .first_mm(firstMmB), .mm_valid(mmValidB)
`endif
    );

    // Function under test for A: combinational lookup of the current minterm.
    assign dutOut = futTable[xVec];

    // Function under test for B: same lookup delayed by two register stages.
    always @(posedge clk) begin
        pipe1B <= tableB[xVecB];
        pipe2B <= pipe1B;
    end
    assign dutOutB = pipe2B;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Onset size of a table.
    function automatic int modelOnes(input logic [127:0] t);
        int n = 0;
        for (int m = 0; m < 128; m++) begin
            if (t[m]) n++;
        end
        return n;
    endfunction

    // Lowest minterm where two tables differ, 0 when equal.
    function automatic int modelFirstMm(input logic [127:0] a, input logic [127:0] b);
        for (int m = 0; m < 128; m++) begin
            if (a[m] != b[m]) return m;
        end
        return 0;
    endfunction

    // Table of the function out = x6.
    function automatic logic [127:0] modelX6();
        logic [127:0] t = '0;
        for (int m = 0; m < 128; m++) begin
            t[m] = ((m >> 6) & 1) == 1;
        end
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic startSweep(input logic [127:0] fut, input logic [127:0] expv);
        futTable = fut;
        start    = 1'b1;
        expTt    = expv;
        @(posedge clk); #1;
        start    = 1'b0;
        expTt    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Full sweep on A with result hand-off; ready held low for readyDelay cycles with a start pulse.
    task automatic applyStimulus(input logic [127:0] fut, input logic [127:0] expv, input int readyDelay);
        int cnt = 0;
        int stable = 1;
        int ones = modelOnes(fut);
        startSweep(fut, expv);
        checkOutput("busyAfterStart", 128'(busy), 128'(1));
        checkOutput("xVecAfterStart", 128'(xVec), 128'(0));
        while (!ttValid && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("latency", 128'(cnt), 128'(128));
        checkOutput("tt", tt, fut);
        checkOutput("onesCount", 128'(onesCount), 128'(ones));
        checkOutput("match", 128'(match), 128'(fut == expv));
        checkOutput("busyInDone", 128'(busy), 128'(0));
`ifdef TT_MISMATCH_IDX_EN
        checkOutput("firstMm", 128'(firstMm), 128'(modelFirstMm(fut, expv)));
        checkOutput("mmValid", 128'(mmValid), 128'(fut != expv));
`endif
        for (int k = 0; k < readyDelay; k++) begin
            if (k == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (!ttValid || tt !== fut || onesCount !== 8'(ones) || busy) stable = 0;
        end
        checkOutput("doneStable", 128'(stable), 128'(1));
        ttReady = 1'b1;
        @(posedge clk); #1;
        ttReady = 1'b0;
        checkOutput("validDrop", 128'(ttValid), 128'(0));
        @(posedge clk); #1;
        checkOutput("noQueuedStart", 128'(busy), 128'(0));
        checkOutput("ttHeldInIdle", tt, fut);
    endtask

    // Abort A once x_vec reaches 'at'; the partial table must hold and tt_valid must stay low.
    task automatic runAbort(input logic [127:0] fut, input int at);
        int cnt = 0;
        int quiet = 1;
        logic [127:0] partial = '0;
        for (int m = 0; m < at; m++) partial[m] = fut[m];
        startSweep(fut, fut);
        while (xVec != 7'(at) && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("abortReach", 128'(xVec), 128'(at));
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abortBusy", 128'(busy), 128'(0));
        checkOutput("abortXVec", 128'(xVec), 128'(0));
        checkOutput("abortPartial", tt, partial);
        for (int k = 0; k < 140; k++) begin
            @(posedge clk); #1;
            if (ttValid || busy || tt !== partial) quiet = 0;
        end
        checkOutput("abortQuiet", 128'(quiet), 128'(1));
    endtask

    initial begin
        logic [127:0] fut;
        logic [127:0] expv;
        logic [127:0] x6;
        int cnt;

        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        ttReady  = 1'b0;
        expTt    = '0;
        futTable = '0;
        startB   = 1'b0;
        abortB   = 1'b0;
        ttReadyB = 1'b0;
        expTtB   = '0;
        tableB   = MAJ;
        #2;
        checkOutput("rstXVec", 128'(xVec), 128'(0));
        checkOutput("rstTt", tt, 128'(0));
        checkOutput("rstOnes", 128'(onesCount), 128'(0));
        checkOutput("rstMatch", 128'(match), 128'(0));
        checkOutput("rstValid", 128'(ttValid), 128'(0));
        checkOutput("rstBusy", 128'(busy), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] majority network, matching table");
        applyStimulus(MAJ, MAJ, 10);

        $display("[TB] out = x6 and constant zero");
        x6 = modelX6();
        applyStimulus(x6, 128'hffffffffffffffff0000000000000000, 2);
        applyStimulus(128'h0, 128'h0, 0);

        $display("[TB] majority with bit 5 flipped in expected table");
        expv = MAJ;
        expv[5] = ~expv[5];
        applyStimulus(MAJ, expv, 1);

        $display("[TB] randomized tables");
        for (int it = 0; it < 6; it++) begin
            fut  = {$urandom, $urandom, $urandom, $urandom};
            expv = fut;
            if ($urandom_range(0, 1) == 1) begin
                for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
                    expv[$urandom_range(0, 127)] ^= 1'b1;
                end
            end
            applyStimulus(fut, expv, int'($urandom_range(0, 5)));
        end
        applyStimulus(128'hffffffffffffffffffffffffffffffff, 128'h0, 0);

        $display("[TB] abort cases");
        runAbort(MAJ, 40);
        runAbort({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(1, 126)));
        runAbort(MAJ, 127);

        $display("[TB] reset mid-sweep");
        startSweep(MAJ, MAJ);
        cnt = 0;
        while (xVec != 7'd70 && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("rstReach", 128'(xVec), 128'(70));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstXVec", 128'(xVec), 128'(0));
        checkOutput("midRstTt", tt, 128'(0));
        checkOutput("midRstOnes", 128'(onesCount), 128'(0));
        checkOutput("midRstBusy", 128'(busy), 128'(0));
        checkOutput("midRstValid", 128'(ttValid), 128'(0));
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("postRstBusy", 128'(busy), 128'(0));

        $display("[TB] SAMPLE_DLY=2 with pipelined FUT");
        startB = 1'b1;
        expTtB = MAJ;
        @(posedge clk); #1;
        startB = 1'b0;
        expTtB = '0;
        cnt = 0;
        while (!ttValidB && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("latencyB", 128'(cnt), 128'(384));
        checkOutput("ttB", ttB, MAJ);
        checkOutput("matchB", 128'(matchB), 128'(1));
        checkOutput("onesB", 128'(onesCountB), 128'(modelOnes(MAJ)));
        ttReadyB = 1'b1;
        @(posedge clk); #1;
        ttReadyB = 1'b0;
        checkOutput("validDropB", 128'(ttValidB), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
